// File: rtl/vga_capture.sv
// VGA capture: locks onto incoming h/v sync timing and emits one write strobe
// per visible pixel with its coordinates and packed colour.
`timescale 1ns/1ps
module vga_capture #(
  parameter int H_VIS_AREA_PXL      = 800,
  parameter int H_FRONT_PORCH_PXL   = 40,
  parameter int H_SYNC_PULSE_PXL    = 128,
  parameter int H_BACK_PORCH_PXL    = 88,
  parameter int H_NUM_BITS          = 11,
  parameter int V_VIS_AREA_PXL      = 600,
  parameter int V_FRONT_PORCH_PXL   = 1,
  parameter int V_SYNC_PULSE_PXL    = 4,
  parameter int V_BACK_PORCH_PXL    = 23,
  parameter int V_NUM_BITS          = 10,
  parameter int RED_CHANNEL_WIDTH   = 3,
  parameter int GREEN_CHANNEL_WIDTH = 3,
  parameter int BLUE_CHANNEL_WIDTH  = 2,
  parameter int LOCK_FRAMES         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            red,
  input  logic [3:0]            green,
  input  logic [3:0]            blue,
  input  logic                  h_sync,
  input  logic                  v_sync,
  output logic                  wr_en,
  output logic [H_NUM_BITS-1:0] wr_x,
  output logic [V_NUM_BITS-1:0] wr_y,
  output logic [RED_CHANNEL_WIDTH+GREEN_CHANNEL_WIDTH+BLUE_CHANNEL_WIDTH-1:0] wr_color,
  output logic                  locked,
  output logic                  frame_done,
  output logic [H_NUM_BITS:0]   h_total,
  output logic [V_NUM_BITS:0]   v_total
);

  localparam int H_WHOLE = H_VIS_AREA_PXL + H_FRONT_PORCH_PXL + H_SYNC_PULSE_PXL + H_BACK_PORCH_PXL;
  localparam int V_WHOLE = V_VIS_AREA_PXL + V_FRONT_PORCH_PXL + V_SYNC_PULSE_PXL + V_BACK_PORCH_PXL;
  localparam int H_START = H_SYNC_PULSE_PXL + H_BACK_PORCH_PXL;
  localparam int V_START = V_SYNC_PULSE_PXL + V_BACK_PORCH_PXL;
  localparam int HW      = H_NUM_BITS + 1;
  localparam int VW      = V_NUM_BITS + 1;
  localparam int GW      = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES);

  localparam logic [HW-1:0] H_WHOLE_L = HW'(H_WHOLE);
  localparam logic [HW-1:0] H_SAT_L   = HW'(2 * H_WHOLE);
  localparam logic [HW-1:0] H_START_L = HW'(H_START);
  localparam logic [HW-1:0] H_END_L   = HW'(H_START + H_VIS_AREA_PXL);
  localparam logic [VW-1:0] V_WHOLE_L = VW'(V_WHOLE);
  localparam logic [VW-1:0] V_SAT_L   = VW'(2 * V_WHOLE);
  localparam logic [VW-1:0] V_START_L = VW'(V_START);
  localparam logic [VW-1:0] V_END_L   = VW'(V_START + V_VIS_AREA_PXL);
  localparam logic [H_NUM_BITS-1:0] X_LAST = H_NUM_BITS'(H_VIS_AREA_PXL - 1);
  localparam logic [V_NUM_BITS-1:0] Y_LAST = V_NUM_BITS'(V_VIS_AREA_PXL - 1);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t          state, state_next;
  logic [3:0]      red_s1, green_s1, blue_s1;
  logic            hs_s1, vs_s1, hs_prev, vs_prev;
  logic            h_fall, v_fall;
  logic [HW-1:0]   h_pos, h_cur, h_len;
  logic [VW-1:0]   v_line, v_cur, v_len;
  logic            h_seen, v_seen;
  logic            line_err, frame_err, timeout, frame_is_bad;
  logic [GW-1:0]   good_frames;
  logic            frame_bad, lock_hit, enter_search, visible;
  logic            unused_color_bits;

  // Only the channel MSBs reach wr_color; the remaining bits are parked here.
  assign unused_color_bits = ^{red_s1, green_s1, blue_s1};

  always_ff @(posedge clk) begin
    if (reset) begin
      red_s1   <= '0;
      green_s1 <= '0;
      blue_s1  <= '0;
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      hs_prev  <= 1'b1;
      vs_prev  <= 1'b1;
    end else begin
      red_s1   <= red;
      green_s1 <= green;
      blue_s1  <= blue;
      hs_s1    <= h_sync;
      vs_s1    <= v_sync;
      hs_prev  <= hs_s1;
      vs_prev  <= vs_s1;
    end
  end

  assign h_fall = hs_prev & ~hs_s1;
  assign v_fall = vs_prev & ~vs_s1;

  // h_cur/v_cur are the coordinates of the sample currently held in S1.
  always_comb begin
    h_cur = h_pos;
    if (h_fall)
      h_cur = '0;
    else if (h_pos != H_SAT_L)
      h_cur = h_pos + 1'b1;
  end

  always_comb begin
    v_cur = v_line;
    if (v_fall)
      v_cur = '0;
    else if (h_fall && (v_line != V_SAT_L))
      v_cur = v_line + 1'b1;
  end

  assign h_len        = h_pos + 1'b1;
  assign v_len        = v_line + 1'b1;
  assign line_err     = h_fall & h_seen & (h_len != H_WHOLE_L);
  assign frame_err    = v_fall & v_seen & (v_len != V_WHOLE_L);
  assign timeout      = (h_cur == H_SAT_L) | (v_cur == V_SAT_L);
  assign frame_is_bad = frame_bad | line_err | frame_err;
  assign lock_hit     = (good_frames == LOCK_LAST);
  assign enter_search = (state != SEARCH) && (state_next == SEARCH);
  assign visible      = (h_cur >= H_START_L) && (h_cur < H_END_L) &&
                        (v_cur >= V_START_L) && (v_cur < V_END_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_pos  <= '0;
      v_line <= '0;
    end else begin
      h_pos  <= h_cur;
      v_line <= v_cur;
    end
  end

  // Dropping back to SEARCH forgets earlier edges so the first new line/frame goes unmeasured.
  always_ff @(posedge clk) begin
    if (reset || enter_search) begin
      h_seen <= 1'b0;
      v_seen <= 1'b0;
    end else begin
      if (h_fall) h_seen <= 1'b1;
      if (v_fall) v_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_total <= '0;
      v_total <= '0;
    end else begin
      if (h_fall && h_seen) h_total <= h_len;
      if (v_fall && v_seen) v_total <= v_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH: if (v_fall) state_next = VERIFY;
      VERIFY: begin
        if (timeout)
          state_next = SEARCH;
        else if (v_fall && !frame_is_bad && lock_hit)
          state_next = LOCKED;
      end
      LOCKED: if (line_err || frame_err || timeout) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      good_frames <= '0;
      frame_bad   <= 1'b0;
    end else if (state == SEARCH) begin
      if (v_fall) begin
        good_frames <= '0;
        frame_bad   <= 1'b0;
      end
    end else if (state == VERIFY) begin
      if (v_fall) begin
        if (frame_is_bad)
          good_frames <= '0;
        else if (!lock_hit)
          good_frames <= good_frames + 1'b1;
        frame_bad <= 1'b0;
      end else if (line_err) begin
        frame_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_color   <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= visible && (state == LOCKED);
      frame_done <= wr_en && (wr_x == X_LAST) && (wr_y == Y_LAST);
      if (visible && (state == LOCKED)) begin
        wr_x     <= H_NUM_BITS'(h_cur - H_START_L);
        wr_y     <= V_NUM_BITS'(v_cur - V_START_L);
        wr_color <= {red_s1[3 -: RED_CHANNEL_WIDTH],
                     green_s1[3 -: GREEN_CHANNEL_WIDTH],
                     blue_s1[3 -: BLUE_CHANNEL_WIDTH]};
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 16x9 raster (8x4 visible).
`timescale 1ns/1ps
module tb_vga_capture;
  localparam int HV = 8, HF = 2, HS = 3, HB = 3, HN = 5;
  localparam int VV = 4, VF = 1, VS = 2, VB = 2, VN = 4;
  localparam int HWH = 16, VWH = 9, HST = 6, VST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    red, green, blue;
  logic          h_sync, v_sync;
  logic          wr_en, locked, frame_done;
  logic [HN-1:0] wr_x;
  logic [VN-1:0] wr_y;
  logic [7:0]    wr_color;
  logic [HN:0]   h_total;
  logic [VN:0]   v_total;

  int n_cmp = 0, n_bad = 0;
  int hc = 0, vc = 0, cur_len = HWH;
  bit force_high = 1'b0;
  int nwr, ex, ey, last_wr, fd_at, nfd;
  bit got, any_wr;

  vga_capture #(
    .H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HF), .H_SYNC_PULSE_PXL(HS),
    .H_BACK_PORCH_PXL(HB), .H_NUM_BITS(HN),
    .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VF), .V_SYNC_PULSE_PXL(VS),
    .V_BACK_PORCH_PXL(VB), .V_NUM_BITS(VN),
    .RED_CHANNEL_WIDTH(3), .GREEN_CHANNEL_WIDTH(3), .BLUE_CHANNEL_WIDTH(2),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .red(red), .green(green), .blue(blue),
    .h_sync(h_sync), .v_sync(v_sync), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .locked(locked), .frame_done(frame_done),
    .h_total(h_total), .v_total(v_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_pins();
    logic [3:0] h4, v4;
    h4     = 4'(hc);
    v4     = 4'(vc);
    h_sync = force_high ? 1'b1 : (hc >= HS);
    v_sync = (vc >= VS);
    red    = h4;
    green  = v4 ^ 4'hA;
    blue   = h4 + v4;
  endtask

  // One clock: outputs are observed 1ns after the edge, then the raster advances.
  task automatic cyc();
    @(posedge clk);
    #1;
    hc++;
    if (hc >= cur_len) begin
      hc      = 0;
      cur_len = HWH;
      vc      = (vc + 1) % VWH;
    end
    drive_pins();
  endtask

  function automatic logic [7:0] exp_color(input int x, input int y);
    logic [3:0] r, g, b;
    r = 4'(x + HST);
    g = 4'(y + VST) ^ 4'hA;
    b = 4'(x + HST) + 4'(y + VST);
    return {r[3:1], g[3:1], b[3:2]};
  endfunction

  task automatic wait_line_start(input int line);
    for (int n = 0; n < 400 && !(hc == 0 && vc == line); n++) cyc();
  endtask

  // Three frame starts: still unlocked after the first two, locked one cycle after the third.
  task automatic relock(input string tag);
    for (int i = 1; i <= 3; i++) begin
      wait_line_start(0);
      cyc();
      chk($sformatf("%s_edge%0d", tag, i), 32'(locked), 32'd0);
      cyc();
      chk($sformatf("%s_after%0d", tag, i), 32'(locked), (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_pins();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_x", 32'(wr_x), 32'd0);
    chk("rst_wr_y", 32'(wr_y), 32'd0);
    chk("rst_wr_color", 32'(wr_color), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_h_total", 32'(h_total), 32'd0);
    chk("rst_v_total", 32'(v_total), 32'd0);
    reset = 1'b0;

    relock("lock0");
    chk("h_total", 32'(h_total), 32'd16);
    chk("v_total", 32'(v_total), 32'd9);
    chk("v_line_on_joint_edge", 32'(dut.v_line), 32'd0);

    nwr = 0; ex = 0; ey = 0; last_wr = -10; fd_at = -1; nfd = 0;
    for (int k = 0; k < VWH * HWH; k++) begin
      cyc();
      if (wr_en) begin
        chk($sformatf("pix_%0d_%0d", ex, ey), 32'({wr_x, wr_y, wr_color}),
            32'({5'(ex), 4'(ey), exp_color(ex, ey)}));
        last_wr = k;
        nwr++;
        ex++;
        if (ex == HV) begin
          ex = 0;
          ey++;
        end
      end
      if (frame_done) begin
        nfd++;
        fd_at = k;
      end
    end
    chk("wr_count", 32'(nwr), 32'd32);
    chk("frame_done_count", 32'(nfd), 32'd1);
    chk("frame_done_timing", 32'(fd_at), 32'(last_wr + 1));
    chk("hold_xy", 32'({wr_x, wr_y}), 32'({5'd7, 4'd3}));

    wait_line_start(2);
    cur_len = HWH - 1;
    wait_line_start(3);
    cyc();
    chk("short_line_still_locked", 32'(locked), 32'd1);
    cyc();
    chk("short_line_unlock", 32'(locked), 32'd0);
    chk("short_line_h_total", 32'(h_total), 32'd15);
    relock("relock_short");

    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      cyc();
      got = wr_en;
    end
    chk("wr_seen_before_reset", 32'(got), 32'd1);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    chk("midreset_outputs",
        32'({wr_en, wr_x, wr_y, wr_color, locked, frame_done, h_total, v_total}), 32'd0);
    reset = 1'b0;
    relock("relock_reset");

    force_high = 1'b1;
    drive_pins();
    any_wr = 1'b0;
    repeat (31) begin
      cyc();
      any_wr = any_wr | wr_en;
    end
    chk("hold_high_before_timeout", 32'(locked), 32'd1);
    cyc();
    chk("hold_high_timeout_unlock", 32'(locked), 32'd0);
    repeat (10) begin
      cyc();
      any_wr = any_wr | wr_en;
    end
    chk("hold_high_no_writes", 32'(any_wr), 32'd0);
    force_high = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters (name, default, meaning): H_VIS_AREA_PXL 800 visible px/line; H_FRONT_PORCH_PXL 40; H_SYNC_PULSE_PXL 128; H_BACK_PORCH_PXL 88; H_NUM_BITS 11; V_VIS_AREA_PXL 600 visible lines; V_FRONT_PORCH_PXL 1; V_SYNC_PULSE_PXL 4; V_BACK_PORCH_PXL 23; V_NUM_BITS 10; RED_CHANNEL_WIDTH 3; GREEN_CHANNEL_WIDTH 3; BLUE_CHANNEL_WIDTH 2; LOCK_FRAMES 2 good frames before lock.
REQ-002 Derived: H_WHOLE = sum of H_* areas (1056); V_WHOLE = sum of V_* areas (628); H_START = H_SYNC_PULSE_PXL+H_BACK_PORCH_PXL; V_START = V_SYNC_PULSE_PXL+V_BACK_PORCH_PXL; CW = RED+GREEN+BLUE widths.
REQ-003 Ports (name direction width meaning): clk in 1 pixel clock; reset in 1 sync active-high reset; red/green/blue in 4 each VGA colour; h_sync in 1 active-low; v_sync in 1 active-low; wr_en out 1 pixel write strobe; wr_x out H_NUM_BITS column; wr_y out V_NUM_BITS row; wr_color out CW packed pixel; locked out 1 timing lock; frame_done out 1 end-of-frame pulse; h_total out H_NUM_BITS+1 last line length; v_total out V_NUM_BITS+1 last frame length.
REQ-004 One clock (clk); reset is synchronous and active-high; all state changes on rising clk.

Function
REQ-005 All inputs registered once (stage S1); all edge detection and counting operate on S1 values.
REQ-006 h-fall = S1 h_sync 1->0; v-fall = S1 v_sync 1->0.
REQ-007 h_pos: 0 on h-fall, else +1, saturating at 2*H_WHOLE.
REQ-008 v_line: 0 on v-fall (wins over simultaneous h-fall), +1 on h-fall, saturating at 2*V_WHOLE.
REQ-009 On h-fall with h_seen set: h_total <= h_pos+1; line error if h_pos+1 != H_WHOLE; h_seen set on first h-fall after reset or entry to SEARCH.
REQ-010 On v-fall with v_seen set: v_total <= v_line+1 (+1 counts the line containing the edge); frame error if != V_WHOLE; v_seen set on first v-fall after reset/SEARCH.
REQ-011 Timeout: h_pos reaching 2*H_WHOLE or v_line reaching 2*V_WHOLE is an error in any state.
REQ-012 FSM states SEARCH, VERIFY, LOCKED; reset -> SEARCH.
REQ-013 SEARCH: on v-fall -> VERIFY, good_frames=0, frame_bad=0.
REQ-014 VERIFY: line error sets frame_bad; on v-fall, if frame_bad or frame error then good_frames=0 else good_frames+1; reaching LOCK_FRAMES -> LOCKED; frame_bad cleared each v-fall; timeout -> SEARCH.
REQ-015 LOCKED: any line, frame or timeout error -> SEARCH same cycle it is detected.
REQ-016 locked = 1 exactly in state LOCKED (registered).
REQ-017 Pixel visible when H_START <= h_pos < H_START+H_VIS_AREA_PXL and V_START <= v_line < V_START+V_VIS_AREA_PXL.
REQ-018 When visible and state LOCKED: next cycle wr_en=1, wr_x=h_pos-H_START, wr_y=v_line-V_START, wr_color={red MSB RED_CHANNEL_WIDTH bits, green MSB GREEN bits, blue MSB BLUE bits}; else wr_en=0, wr_x/wr_y/wr_color hold.
REQ-019 Latency pins -> wr_*: 2 cycles (S1 + output register).
REQ-020 frame_done: 1-cycle pulse, cycle after wr_en for pixel (H_VIS-1, V_VIS-1).
REQ-021 Arithmetic unsigned; counters never wrap (saturate per REQ-007/008).

Reset
REQ-022 Reset: wr_en=0, wr_x=0, wr_y=0, wr_color=0, locked=0, frame_done=0, h_total=0, v_total=0, h_pos=0, v_line=0, h_seen=v_seen=0, good_frames=0, state SEARCH, S1 h_sync/v_sync=1.
REQ-023 Reset mid-frame: outputs at reset values the cycle after reset sampled; relock requires full REQ-013/014 sequence.

Verification
REQ-024 Drive from default 800x600 timing generator after reset -> locked rises 1 cycle after 3rd v-fall seen at S1; h_total=1056, v_total=628.
REQ-025 Locked, colour = pixel index pattern -> exactly 480000 wr_en per frame, first write x=0,y=0, last x=799,y=599 followed by frame_done=1 one cycle.
REQ-026 Locked, one line shortened to 1055 cycles -> locked falls cycle after that h-fall, h_total=1055; relock after 3 further clean v-falls.
REQ-027 Locked, h_sync held high -> locked falls when h_pos hits 2112; wr_en stays 0.
REQ-028 Reset asserted mid-frame while locked -> next cycle all outputs 0, state SEARCH.
REQ-029 Custom params aligning h-fall and v-fall same cycle -> v_line=0 after that cycle.
